// File: rtl/uart_alu_ctrl.sv
// Command sequencer between UART RX, the combinational ALU and UART TX: collects A, B, opcode, then sends one result.
// Optional inter-byte timeout enabled by defining UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
    parameter int D_BIT         = 8,
    parameter int OP_WIDTH      = 6,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_s_tick,
    input  logic                i_rx_done_tick,
    input  logic [D_BIT-1:0]    i_rx_data,
    input  logic [D_BIT-1:0]    i_alu_result,
    input  logic                i_tx_done_tick,
    output logic [D_BIT-1:0]    o_alu_a,
    output logic [D_BIT-1:0]    o_alu_b,
    output logic [OP_WIDTH-1:0] o_alu_op,
    output logic                o_tx_start,
    output logic [D_BIT-1:0]    o_tx_data,
    output logic                o_busy,
    output logic                o_drop_tick,
    output logic                o_err_timeout
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t                state_q;
    logic [D_BIT-1:0]      alu_a_q;
    logic [D_BIT-1:0]      alu_b_q;
    logic [OP_WIDTH-1:0]   alu_op_q;
    logic [D_BIT-1:0]      tx_data_q;
    logic                  tx_start_q;
    logic                  busy_q;
    logic                  drop_q;
    logic                  err_q;
    logic                  tmo_hit;

    if (TIMEOUT_TICKS < 2) begin : g_bad_timeout
        $error("TIMEOUT_TICKS must be at least 2");
    end

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_TICKS + 1);

    logic [CW-1:0] tmo_cnt_q;
    logic [CW-1:0] tmo_cnt_d;

    // An accepted byte wins over the expiring tick in the same cycle.
    always_comb begin
        tmo_cnt_d = '0;
        tmo_hit   = 1'b0;
        if (state_q == WAIT_B || state_q == WAIT_OP) begin
            tmo_cnt_d = tmo_cnt_q;
            if (i_rx_done_tick) begin
                tmo_cnt_d = '0;
            end else if (i_s_tick) begin
                if (tmo_cnt_q == CW'(TIMEOUT_TICKS - 1)) begin
                    tmo_hit   = 1'b1;
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_s_tick;
    assign unused_s_tick = i_s_tick;
    assign tmo_hit       = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            drop_q     <= 1'b0;
            err_q      <= tmo_hit;
            case (state_q)
                WAIT_A: begin
                    if (i_rx_done_tick) begin
                        alu_a_q <= i_rx_data;
                        state_q <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done_tick) begin
                        alu_b_q <= i_rx_data;
                        state_q <= WAIT_OP;
                    end else if (tmo_hit) begin
                        state_q <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done_tick) begin
                        alu_op_q <= i_rx_data[OP_WIDTH-1:0];
                        busy_q   <= 1'b1;
                        state_q  <= EXEC;
                    end else if (tmo_hit) begin
                        state_q <= WAIT_A;
                    end
                end
                EXEC: begin
                    tx_data_q  <= i_alu_result;
                    tx_start_q <= 1'b1;
                    drop_q     <= i_rx_done_tick;
                    state_q    <= SEND;
                end
                SEND: begin
                    drop_q  <= i_rx_done_tick;
                    state_q <= WAIT_TX;
                end
                WAIT_TX: begin
                    // A byte arriving with tx_done starts the next command rather than being dropped.
                    if (i_tx_done_tick) begin
                        busy_q <= 1'b0;
                        if (i_rx_done_tick) begin
                            alu_a_q <= i_rx_data;
                            state_q <= WAIT_B;
                        end else begin
                            state_q <= WAIT_A;
                        end
                    end else begin
                        drop_q <= i_rx_done_tick;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= WAIT_A;
                end
            endcase
        end
    end

    assign o_alu_a       = alu_a_q;
    assign o_alu_b       = alu_b_q;
    assign o_alu_op      = alu_op_q;
    assign o_tx_data     = tx_data_q;
    assign o_tx_start    = tx_start_q;
    assign o_busy        = busy_q;
    assign o_drop_tick   = drop_q;
    assign o_err_timeout = err_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: directed command sequences plus randomized traffic against a transaction-level model.
module tb_uart_alu_ctrl;

    localparam int TT = 32;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] alu_result;
    logic [7:0] alu_a, alu_b, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, busy, drop, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_op);

    uart_alu_ctrl #(.D_BIT(8), .OP_WIDTH(6), .TIMEOUT_TICKS(TT)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_s_tick       (s_tick),
        .i_rx_done_tick (rx_done),
        .i_rx_data      (rx_data),
        .i_alu_result   (alu_result),
        .i_tx_done_tick (tx_done),
        .o_alu_a        (alu_a),
        .o_alu_b        (alu_b),
        .o_alu_op       (alu_op),
        .o_tx_start     (tx_start),
        .o_tx_data      (tx_data),
        .o_busy         (busy),
        .o_drop_tick    (drop),
        .o_err_timeout  (err)
    );

    // Model: bytes collected so far, and cycles elapsed since the opcode byte (0 = no command in flight).
    int         nbytes, since_op, ticks;
    logic [7:0] m_a, m_b, m_tx;
    logic [5:0] m_op;
    logic       m_start, m_busy, m_drop, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nbytes = 0; since_op = 0; ticks = 0;
            m_a = 0; m_b = 0; m_op = 0; m_tx = 0;
            m_start = 0; m_busy = 0; m_drop = 0; m_err = 0;
        end else begin
            m_start = 0; m_drop = 0; m_err = 0;
            if (since_op == 0) begin
                if (rx_done) begin
                    if (nbytes == 0) m_a = rx_data;
                    else if (nbytes == 1) m_b = rx_data;
                    else m_op = rx_data[5:0];
                    nbytes++;
                    ticks = 0;
                    if (nbytes == 3) begin
                        nbytes = 0;
                        since_op = 1;
                    end
                end else if (TO_EN && nbytes > 0 && s_tick) begin
                    ticks++;
                    if (ticks == TT) begin
                        m_err = 1; nbytes = 0; ticks = 0;
                    end
                end
            end else if (since_op == 1) begin
                m_tx = alu_fn(m_a, m_b, m_op);
                m_start = 1;
                m_drop = rx_done;
                since_op = 2;
            end else if (since_op == 2) begin
                m_drop = rx_done;
                since_op = 3;
            end else if (tx_done) begin
                since_op = 0;
                if (rx_done) begin
                    m_a = rx_data; nbytes = 1; ticks = 0;
                end
            end else begin
                m_drop = rx_done;
            end
            m_busy = (since_op != 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_alu_a", 32'(alu_a), 32'(m_a));
            chk("m_alu_b", 32'(alu_b), 32'(m_b));
            chk("m_alu_op", 32'(alu_op), 32'(m_op));
            chk("m_tx_data", 32'(tx_data), 32'(m_tx));
            chk("m_tx_start", 32'(tx_start), 32'(m_start));
            chk("m_busy", 32'(busy), 32'(m_busy));
            chk("m_drop", 32'(drop), 32'(m_drop));
            chk("m_err", 32'(err), 32'(m_err));
        end
    end

    // Called at a falling edge; inputs are held for exactly one rising edge.
    task automatic step(input logic rx, input logic [7:0] d, input logic txd, input logic tk);
        rx_done = rx; rx_data = d; tx_done = txd; s_tick = tk;
        @(negedge clk);
        rx_done = 1'b0; tx_done = 1'b0; s_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a", 32'(alu_a), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(tx_start), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic command
        step(1, 8'h05, 0, 0);
        step(0, 8'h00, 0, 1);
        step(1, 8'h03, 0, 0);
        step(1, 8'h20, 0, 0);
        chk("basic_a", 32'(alu_a), 32'h05);
        chk("basic_b", 32'(alu_b), 32'h03);
        chk("basic_op", 32'(alu_op), 32'h20);
        chk("exec_busy", 32'(busy), 1);
        chk("exec_start", 32'(tx_start), 0);
        idle(1);
        chk("start_n2", 32'(tx_start), 1);
        chk("tx_data", 32'(tx_data), 32'h08);
        idle(1);
        chk("start_once", 32'(tx_start), 0);
        chk("wait_busy", 32'(busy), 1);

        // drop during WAIT_TX
        step(1, 8'h7F, 0, 0);
        chk("drop_pulse", 32'(drop), 1);
        chk("drop_a", 32'(alu_a), 32'h05);
        chk("drop_op", 32'(alu_op), 32'h20);
        idle(1);
        chk("drop_once", 32'(drop), 0);
        step(0, 8'h00, 1, 0);
        chk("txdone_busy", 32'(busy), 0);
        step(1, 8'h11, 0, 0);
        chk("after_a", 32'(alu_a), 32'h11);

        // opcode masking
        step(1, 8'h22, 0, 0);
        step(1, 8'hE6, 0, 0);
        chk("op_mask", 32'(alu_op), 32'h26);
        idle(2);

        // tx_done and rx_done together
        step(1, 8'h42, 1, 0);
        chk("simul_drop", 32'(drop), 0);
        chk("simul_a", 32'(alu_a), 32'h42);
        chk("simul_busy", 32'(busy), 0);
        step(1, 8'h0C, 0, 0);
        chk("simul_b", 32'(alu_b), 32'h0C);
        step(1, 8'h01, 0, 0);
        idle(3);
        step(0, 8'h00, 1, 0);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
        step(1, 8'hAA, 0, 0);
        for (int i = 0; i < TT; i++) begin
            step(0, 8'h00, 0, 0);
            step(0, 8'h00, 0, 1);
        end
        chk("tmo_pulse", 32'(err), 1);
        chk("tmo_keep_a", 32'(alu_a), 32'hAA);
        idle(1);
        chk("tmo_once", 32'(err), 0);
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'h04, 0, 0);
        chk("tmo_a", 32'(alu_a), 32'h01);
        chk("tmo_b", 32'(alu_b), 32'h02);
        chk("tmo_op", 32'(alu_op), 32'h04);
        idle(3);
        step(0, 8'h00, 1, 0);
        step(1, 8'h55, 0, 0);
        for (int i = 0; i < TT - 1; i++) step(0, 8'h00, 0, 1);
        step(1, 8'h66, 0, 1);
        chk("tmo_race_err", 32'(err), 0);
        chk("tmo_race_b", 32'(alu_b), 32'h66);
        step(1, 8'h07, 0, 0);
        idle(3);
        step(0, 8'h00, 1, 0);
`endif

        // reset in WAIT_OP
        step(1, 8'h09, 0, 0);
        step(1, 8'h0C, 0, 0);
        chk("pre_rst_b", 32'(alu_b), 32'h0C);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a", 32'(alu_a), 0);
        chk("arst_b", 32'(alu_b), 0);
        chk("arst_op", 32'(alu_op), 0);
        chk("arst_tx", 32'(tx_data), 0);
        chk("arst_flags", 32'({tx_start, busy, drop, err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1, 8'h33, 0, 0);
        chk("post_rst_a", 32'(alu_a), 32'h33);
        chk("post_rst_b", 32'(alu_b), 0);
        step(1, 8'h10, 0, 0);
        step(1, 8'h03, 0, 0);
        idle(3);
        step(0, 8'h00, 1, 0);

        // randomized traffic: alternate dense and sparse byte streams
        for (int i = 0; i < 4000; i++) begin
            int rxp;
            rxp = ((i / 500) % 2 == 1) ? 40 : 4;
            step($urandom_range(0, rxp - 1) == 0, 8'($urandom),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
